// File: rtl/playfield_store_if.sv
// playfield_store_if: color type plus the piece/query bus between the game engine and the playfield.
package playfield_pkg;
  typedef enum logic [2:0] {EMPTY, CYAN, BLUE, ORANGE, YELLOW, GREEN, PURPLE, RED} block_color;
endpackage

interface playfield_store_if;
  import playfield_pkg::*;
  logic [19:0] x_block, y_block, save_xblock, save_yblock;
  block_color block, cell_color;
  logic lock, busy;
  logic [4:0] x_coord, y_coord;
  logic [7:0] lines_cleared;
  modport master (
    output x_block, y_block, save_xblock, save_yblock, block, lock, x_coord, y_coord,
    input cell_color, busy, lines_cleared
  );
  modport slave (
    input x_block, y_block, save_xblock, save_yblock, block, lock, x_coord, y_coord,
    output cell_color, busy, lines_cleared
  );
endinterface

// File: rtl/playfield_store.sv
// playfield_store: FIELD_W x FIELD_H color registers rewritten by an erase/write FSM on every piece move.
// Defining PLAYFIELD_LINE_CLEAR_EN adds full-row scan and collapse after each lock.
module playfield_store
  import playfield_pkg::*;
#(
  parameter int FIELD_W = 10,
  parameter int FIELD_H = 20
) (
  input logic Clk,
  input logic Reset,
  playfield_store_if.slave pf
);
  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);
  localparam logic [4:0] W5 = 5'(FIELD_W);
  localparam logic [4:0] H5 = 5'(FIELD_H);
`ifdef PLAYFIELD_LINE_CLEAR_EN
  typedef enum logic [2:0] {IDLE, ERASE, WRITE, SCAN, SHIFT} state_t;
  logic [YW-1:0] row;
  logic full;
`else
  typedef enum logic [1:0] {IDLE, ERASE, WRITE} state_t;
`endif
  state_t state;
  block_color field [FIELD_H][FIELD_W];
  block_color col, pcol, wc;
  logic [19:0] ox, oy, nx, ny, pox, poy, pnx, pny;
  logic [4:0] cx, cy;
  logic [1:0] idx;
  logic move_pend, lock_pend, suppress, mv, go, ok;
  always_comb begin
    mv = {pf.x_block, pf.y_block} != {pf.save_xblock, pf.save_yblock};
    go = mv || move_pend;
    cx = state == ERASE ? ox[5*idx +: 5] : nx[5*idx +: 5];
    cy = state == ERASE ? oy[5*idx +: 5] : ny[5*idx +: 5];
    ok = cx < W5 && cy < H5 && !(state == ERASE && suppress);
    wc = state == ERASE ? EMPTY : col;
  end
`ifdef PLAYFIELD_LINE_CLEAR_EN
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < FIELD_W; c++) full = full && field[row][c] != EMPTY;
  end
`else
  assign pf.lines_cleared = 8'd0;
`endif
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < FIELD_H; r++)
        for (int c = 0; c < FIELD_W; c++) field[r][c] <= EMPTY;
      state <= IDLE;
      pf.busy <= 1'b0;
      pf.cell_color <= EMPTY;
      {ox, oy, nx, ny, pox, poy, pnx, pny} <= '0;
      col <= EMPTY;
      pcol <= EMPTY;
      idx <= '0;
      {move_pend, lock_pend, suppress} <= '0;
`ifdef PLAYFIELD_LINE_CLEAR_EN
      row <= '0;
      pf.lines_cleared <= '0;
`endif
    end else begin
      pf.cell_color <= pf.x_coord < W5 && pf.y_coord < H5 ?
                       field[pf.y_coord[YW-1:0]][pf.x_coord[XW-1:0]] : EMPTY;
      // moves arriving while busy collapse into one pending slot, newest wins
      if (state != IDLE && mv) begin
        move_pend <= 1'b1;
        {pox, poy, pnx, pny} <= {pf.save_xblock, pf.save_yblock, pf.x_block, pf.y_block};
        pcol <= pf.block;
      end
      if (state != IDLE && pf.lock) lock_pend <= 1'b1;
      case (state)
        IDLE:
          if (go) begin
            {ox, oy, nx, ny} <= mv ? {pf.save_xblock, pf.save_yblock, pf.x_block, pf.y_block}
                                   : {pox, poy, pnx, pny};
            col <= mv ? pf.block : pcol;
            move_pend <= 1'b0;
            if (pf.lock) lock_pend <= 1'b1;
            idx <= '0;
            state <= ERASE;
            pf.busy <= 1'b1;
          end else if (pf.lock || lock_pend) begin
            lock_pend <= 1'b0;
            suppress <= 1'b1;
`ifdef PLAYFIELD_LINE_CLEAR_EN
            row <= YW'(FIELD_H - 1);
            state <= SCAN;
            pf.busy <= 1'b1;
`endif
          end
        ERASE, WRITE: begin
          if (ok) field[cy[YW-1:0]][cx[XW-1:0]] <= wc;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            if (state == ERASE) suppress <= 1'b0;
            state <= state == ERASE ? WRITE : IDLE;
            pf.busy <= state == ERASE;
          end
        end
`ifdef PLAYFIELD_LINE_CLEAR_EN
        SCAN:
          if (full) state <= SHIFT;
          else if (row == '0) begin
            state <= IDLE;
            pf.busy <= 1'b0;
          end else row <= row - YW'(1);
        // collapse everything above the full row, then rescan the same index
        SHIFT: begin
          for (int r = 1; r < FIELD_H; r++) if (r <= int'(row)) field[r] <= field[r-1];
          for (int c = 0; c < FIELD_W; c++) field[0][c] <= EMPTY;
          pf.lines_cleared <= pf.lines_cleared + 8'd1;
          state <= SCAN;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/playfield_store.md
PLAYFIELD_STORE -- requirements
Module: playfield_store

Interface
REQ-001 SHALL declare parameter FIELD_W, default 10, meaning number of playfield columns.
REQ-002 SHALL declare parameter FIELD_H, default 20, meaning number of playfield rows.
REQ-003 SHALL have port Clk, input, 1, meaning the 50 MHz system clock.
REQ-004 SHALL have port Reset, input, 1, meaning reset; Reset SHALL be asynchronous and active-high.
REQ-005 SHALL have port x_block, input, 20, meaning the current piece columns, packed as four 5-bit cells, with cell 3 in bits [19:15].
REQ-006 SHALL have port y_block, input, 20, meaning the current piece rows, packed the same way as x_block.
REQ-007 SHALL have port save_xblock, input, 20, meaning the previous piece columns.
REQ-008 SHALL have port save_yblock, input, 20, meaning the previous piece rows.
REQ-009 SHALL have port block, input, block_color, meaning the active piece color; EMPTY encodes 0.
REQ-010 SHALL have port lock, input, 1, meaning a one-cycle pulse that freezes the current piece into the field.
REQ-011 SHALL have port x_coord, input, 5, meaning the pixel-query column.
REQ-012 SHALL have port y_coord, input, 5, meaning the pixel-query row.
REQ-013 SHALL have port cell_color, output, block_color, meaning the registered color of the queried cell.
REQ-014 SHALL have port busy, output, 1, meaning an update or clear is in progress.
REQ-015 SHALL have port lines_cleared, output, 8, meaning the total number of rows cleared; it wraps at 255 back to 0.

Function
REQ-016 SHALL store FIELD_W x FIELD_H cells of block_color in registers.
REQ-017 SHALL present cell_color one cycle after x_coord/y_coord; a query with x_coord>=FIELD_W or y_coord>=FIELD_H SHALL return EMPTY.
REQ-018 SHALL detect a move when {x_block,y_block} differs from {save_xblock,save_yblock}, and on a detected move SHALL latch old coordinates, new coordinates and block into shadow registers.
REQ-019 FSM states SHALL be IDLE, ERASE, WRITE, SCAN, SHIFT.
REQ-020 IDLE SHALL go to ERASE on a detected move; busy SHALL be 1 in every state except IDLE.
REQ-021 ERASE SHALL write EMPTY to the four old cells, one cell per cycle (index 0..3), then go to WRITE.
REQ-022 WRITE SHALL write the latched color to the four new cells, one cell per cycle, then go to IDLE; a full update therefore takes 8 cycles.
REQ-023 Any cell with x>=FIELD_W or y>=FIELD_H SHALL be skipped, with no write, while still consuming its cycle.
REQ-024 A move detected while busy SHALL set a single pending flag and overwrite the shadow registers with the newest move; the pending move SHALL be serviced starting the cycle after IDLE is re-entered, and intermediate moves SHALL be dropped.
REQ-025 lock in IDLE SHALL go to SCAN (LINE_CLEAR_EN) or remain in IDLE (without LINE_CLEAR_EN); lock while busy SHALL be held pending and taken after any pending move completes.
REQ-026 A lock and a move in the same cycle SHALL process the move first, then the lock.
REQ-027 A locked piece's cells SHALL never be erased: after a lock, the next ERASE SHALL be suppressed, writing nothing while still taking 4 cycles.

Reset
REQ-028 Reset SHALL clear all cells to EMPTY.
REQ-029 Reset SHALL set the FSM to IDLE, clear the pending flags, and set busy=0, cell_color=EMPTY and lines_cleared=0.
REQ-030 Reset asserted mid-update SHALL abort immediately, leaving no partial write after deassertion.

Configuration
REQ-031 With macro PLAYFIELD_LINE_CLEAR_EN defined: SCAN SHALL test rows FIELD_H-1 down to 0, one row per cycle; a full row SHALL enter SHIFT, which copies every row above down by one in one cycle, sets row 0 EMPTY, increments lines_cleared, and rescans the same row index; SCAN past row 0 SHALL return to IDLE.
REQ-032 Without PLAYFIELD_LINE_CLEAR_EN: SCAN and SHIFT SHALL not exist, lock SHALL only perform the REQ-027 suppression, and lines_cleared SHALL be tied to 0.

Verification
REQ-033 Reset, then query (0,0) -> cell_color=EMPTY the next cycle, busy=0, lines_cleared=0.
REQ-034 save x={3,4,5,6},y={0,0,0,0}, new y={1,1,1,1}, block=CYAN -> busy for 8 cycles; afterwards (3..6,0)=EMPTY and (3..6,1)=CYAN.
REQ-035 Three moves 1 cycle apart -> only the first and last moves are applied; final cells match the last move only.
REQ-036 Piece at x={0,1,2,3}, y=19 with new x={20,21,22,23} -> the out-of-range writes are skipped, no other cell changes, and busy lasts 8 cycles.
REQ-037 (LINE_CLEAR_EN) Rows 18 and 19 full, lock -> two rows cleared, lines_cleared=2, old row 17 contents appear in row 19.
REQ-038 Reset asserted at cycle 3 of WRITE -> all cells EMPTY and FSM in IDLE after release.
